// File: rtl/mac_result_serializer.sv
// Purpose: buffers 16-bit MAC results in a DEPTH-word FIFO and sends them byte-wide, low byte first.
// Latency: a word written into an empty FIFO appears on out_byte the cycle after the write edge.
// Backpressure: out_valid/out_byte hold while out_ready is low; a write into a full FIFO with no pop is dropped and sets overflow.
// Option: MAC_SER_DROP_CNT_EN adds a saturating drop_cnt output and derives overflow from it.
module mac_result_serializer #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        full,
  output logic        empty,
`ifdef MAC_SER_DROP_CNT_EN
  output logic        overflow,
  output logic [7:0]  drop_cnt
`else
  output logic        overflow
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {PH_LO, PH_HI} phase_t;

  phase_t           phase_q, phase_d;
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      head;
  logic             beat, pop, full_acc, wr_en, drop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = !empty;
  assign head      = mem[rd_ptr];
  assign out_byte  = (phase_q == PH_HI) ? head[15:8] : head[7:0];
  assign out_last  = (phase_q == PH_HI) && out_valid;

  assign beat     = out_valid && out_ready;
  assign pop      = beat && (phase_q == PH_HI);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign full_acc = full && !pop;
  assign wr_en    = in_valid && !full_acc;
  assign drop     = in_valid && full_acc;

  always_comb begin
    phase_d = phase_q;
    if (beat) begin
      phase_d = (phase_q == PH_LO) ? PH_HI : PH_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_LO;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !wr_en) begin
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef MAC_SER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign overflow = (drop_cnt != 8'd0);
`else
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed bench for mac_result_serializer: inputs driven and outputs sampled on the falling edge.
module tb_mac_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        full;
  logic        empty;
  logic        overflow;
`ifdef MAC_SER_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mac_result_serializer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .full      (full),
    .empty     (empty),
`ifdef MAC_SER_DROP_CNT_EN
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
`else
    .overflow  (overflow)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consumes exp_q with out_ready high, one byte per cycle, then expects empty.
  task automatic drain_check(input string tag);
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_byte"}, 32'(out_byte), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    check({tag, "_empty"}, 32'(empty), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    do_reset();

    // Idle after reset: {out_valid, empty, full, overflow, out_last}
    for (int i = 0; i < 10; i++) begin
      check("idle", {27'd0, out_valid, empty, full, overflow, out_last}, 32'b01000);
      @(negedge clk);
    end

    // Single word, consumer always ready
    out_ready = 1'b1;
    write_word(16'hA55A);
    check("single_lo", {23'd0, out_valid, out_byte}, {23'd0, 1'b1, 8'h5A});
    check("single_lo_last", 32'(out_last), 32'd0);
    @(negedge clk);
    check("single_hi", {23'd0, out_valid, out_byte}, {23'd0, 1'b1, 8'hA5});
    check("single_hi_last", 32'(out_last), 32'd1);
    @(negedge clk);
    check("single_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Backpressure: byte holds while not ready
    write_word(16'h1234);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {23'd0, out_valid, out_byte}, {23'd0, 1'b1, 8'h34});
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp_lo", {23'd0, out_last, out_byte}, {23'd0, 1'b0, 8'h34});
    @(negedge clk);
    check("bp_hi", {23'd0, out_last, out_byte}, {23'd0, 1'b1, 8'h12});
    @(negedge clk);
    check("bp_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Fill and drop the fifth word
    for (int i = 1; i <= 5; i++) begin
      write_word(16'(i));
      if (i == 4) check("fill_full4", 32'(full), 32'd1);
      if (i == 4) check("fill_ovf4", 32'(overflow), 32'd0);
    end
    check("fill_ovf", 32'(overflow), 32'd1);
    check("fill_full5", 32'(full), 32'd1);
`ifdef MAC_SER_DROP_CNT_EN
    check("fill_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    exp_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    drain_check("fill_drain");
    check("fill_ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous pop and write
    do_reset();
    check("rst_ovf_clear", 32'(overflow), 32'd0);
    write_word(16'h0011);
    write_word(16'h0022);
    write_word(16'h0033);
    write_word(16'h0044);
    check("fp_full", 32'(full), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("fp_phase_hi", {23'd0, out_last, out_byte}, {23'd0, 1'b1, 8'h00});
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    check("fp_ovf", 32'(overflow), 32'd0);
    check("fp_full_after", 32'(full), 32'd1);
    exp_q = '{8'h22, 8'h00, 8'h33, 8'h00, 8'h44, 8'h00, 8'hEF, 8'hBE};
    drain_check("fp_drain");

    // Continuous stream across pointer wrap, one word every two cycles
    begin
      int sent = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (out_valid) begin
          if (exp_q.size() == 0) check("wrap_extra", 32'(out_byte), 32'hFFFF_FFFF);
          else check("wrap_byte", 32'(out_byte), 32'(exp_q.pop_front()));
        end
        if ((cyc % 2 == 0) && (sent < 10)) begin
          in_valid = 1'b1;
          in_data  = 16'h1000 + 16'(sent) * 16'h0101;
          exp_q.push_back(in_data[7:0]);
          exp_q.push_back(in_data[15:8]);
          sent++;
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("wrap_all_out", 32'(exp_q.size()), 32'd0);
      check("wrap_ovf", 32'(overflow), 32'd0);
      check("wrap_empty", 32'(empty), 32'd1);
      exp_q.delete();
      out_ready = 1'b0;
    end

    // Reset while the high byte of a word is pending
    write_word(16'h7788);
    write_word(16'h99AA);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rmw_hi", {23'd0, out_last, out_byte}, {23'd0, 1'b1, 8'h77});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rmw_state", {29'd0, empty, out_valid, out_last}, {29'd0, 3'b100});
    write_word(16'h0102);
    check("rmw_lo", {23'd0, out_last, out_byte}, {23'd0, 1'b0, 8'h02});
    out_ready = 1'b1;
    @(negedge clk);
    check("rmw_hi2", {23'd0, out_last, out_byte}, {23'd0, 1'b1, 8'h01});
    @(negedge clk);
    check("rmw_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
